// File: rtl/mem_pkg.sv
// Shared definitions for the memory port arbiter: size codes, FSM states and lane math.
package mem_pkg;

  // Size codes used by both the load (MemRead) and store (MemWrite) fields.
  localparam logic [1:0] SZ_NONE = 2'd0;
  localparam logic [1:0] SZ_WORD = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;
  localparam logic [1:0] SZ_HALF = 2'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH_A = 3'd1,
    FETCH_D = 3'd2,
    LOAD_A  = 3'd3,
    LOAD_D  = 3'd4,
    STORE_W = 3'd5,
    RMW_A   = 3'd6,
    RMW_W   = 3'd7
  } mem_state_t;

  // Right-shift that brings the addressed lane down to bit 0 (big-endian byte order).
  function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] addr);
    logic [4:0] sh;
    case (size)
      SZ_BYTE: sh = 5'd24 - {addr, 3'b000};
      SZ_HALF: sh = addr[1] ? 5'd0 : 5'd16;
      default: sh = 5'd0;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane alignment: load extract with sign extension and store read-modify-write merge.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr,
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  function automatic logic signed [31:0] sext8(input logic [7:0] b);
    logic signed [7:0] s;
    s = b;
    return 32'(s);
  endfunction

  function automatic logic signed [31:0] sext16(input logic [15:0] h);
    logic signed [15:0] s;
    s = h;
    return 32'(s);
  endfunction

  logic [4:0]  sh;
  logic [31:0] shifted;
  logic [31:0] mask;

  // Extract the addressed lane for loads and merge the new lane into the old word for stores.
  always_comb begin
    sh      = lane_shift(size, addr);
    shifted = old_word >> sh;
    case (size)
      SZ_BYTE: begin
        load_data = sext8(shifted[7:0]);
        mask      = 32'h0000_00FF << sh;
      end
      SZ_HALF: begin
        load_data = sext16(shifted[15:0]);
        mask      = 32'h0000_FFFF << sh;
      end
      default: begin
        load_data = old_word;
        mask      = 32'hFFFF_FFFF;
      end
    endcase
    store_word = (old_word & ~mask) | ((new_data << sh) & mask);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one synchronous-read word memory between instruction fetch and load/store.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int MEM_AW     = 10,
  parameter int STARVE_MAX = 3
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              IfReq,
  input  logic [31:0]       IfAddr,
  output logic              IfGnt,
  output logic [31:0]       IfRdata,
  input  logic              DReq,
  input  logic [1:0]        DRead,
  input  logic [1:0]        DWrite,
  input  logic [31:0]       DAddr,
  input  logic [31:0]       DWdata,
  output logic              DGnt,
  output logic [31:0]       DRdata,
  output logic              AddrErr,
  output logic              Busy,
  output logic [MEM_AW-1:0] MemAddr,
  output logic              MemWe,
  output logic [31:0]       MemWdata,
  input  logic [31:0]       MemRdata
);

  localparam int SW = $clog2(STARVE_MAX + 2);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  mem_state_t    state, state_nxt;
  logic [SW-1:0] starve_cnt;
  logic [1:0]    sz_q;
  logic [1:0]    lane_q;
  logic [31:0]   wdata_q;
  logic          err_q;

  logic          d_is_load, d_is_store, d_misalign, d_bad;
  logic [1:0]    d_size;
  logic          arb_en, fetch_win, data_win;
  logic [31:0]   load_data, store_word;

  // Upper address bits and the fetch byte offset are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{IfAddr[31:MEM_AW+2], IfAddr[1:0], DAddr[31:MEM_AW+2]};

  // Request decode and arbitration; the cycle carrying an error response is not an arbitration slot.
  always_comb begin
    d_is_load  = (DRead != SZ_NONE);
    d_is_store = (DWrite != SZ_NONE);
    d_size     = d_is_load ? DRead : DWrite;
    d_misalign = ((d_size == SZ_WORD) && (DAddr[1:0] != 2'b00)) ||
                 ((d_size == SZ_HALF) && DAddr[0]);
    d_bad      = (d_is_load == d_is_store) || d_misalign;
    arb_en     = (state == IDLE) && !err_q;
    fetch_win  = arb_en && IfReq && (!DReq || (starve_cnt == STARVE_LIM));
    data_win   = arb_en && DReq && !fetch_win;
  end

  // Next-state logic; every access terminates back in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (fetch_win)
          state_nxt = FETCH_A;
        else if (data_win && !d_bad) begin
          if (d_is_load)               state_nxt = LOAD_A;
          else if (DWrite == SZ_WORD)  state_nxt = STORE_W;
          else                         state_nxt = RMW_A;
        end
      end
      FETCH_A: state_nxt = FETCH_D;
      FETCH_D: state_nxt = IDLE;
      LOAD_A:  state_nxt = LOAD_D;
      LOAD_D:  state_nxt = IDLE;
      STORE_W: state_nxt = IDLE;
      RMW_A:   state_nxt = RMW_W;
      RMW_W:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, starvation counter and latched request fields; reset aborts any access in flight.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      sz_q       <= SZ_NONE;
      lane_q     <= 2'b00;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      MemAddr    <= '0;
      MemWe      <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= data_win && d_bad;
      // Write enable is registered so it lines up with STORE_W and RMW_W.
      MemWe <= (state_nxt == STORE_W) || (state_nxt == RMW_W);
      if (arb_en) begin
        if (!IfReq || fetch_win)
          starve_cnt <= '0;
        else if (data_win && (starve_cnt != STARVE_LIM))
          starve_cnt <= starve_cnt + 1'b1;
      end
      if (fetch_win)
        MemAddr <= IfAddr[MEM_AW+1:2];
      if (data_win) begin
        MemAddr <= DAddr[MEM_AW+1:2];
        sz_q    <= d_size;
        lane_q  <= DAddr[1:0];
        wdata_q <= DWdata;
      end
    end
  end

  mem_lane_align u_align (
    .size       (sz_q),
    .addr       (lane_q),
    .old_word   (MemRdata),
    .new_data   (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // Moore-style responses; the merged word is only known once read data returns in RMW_W.
  always_comb begin
    IfGnt    = (state == FETCH_D);
    IfRdata  = IfGnt ? MemRdata : 32'h0;
    DGnt     = (state == LOAD_D) || (state == STORE_W) || (state == RMW_W) || err_q;
    AddrErr  = err_q;
    DRdata   = (state == LOAD_D) ? load_data : 32'h0;
    Busy     = (state != IDLE);
    MemWdata = (state == RMW_W) ? store_word : wdata_q;
  end

endmodule
